// File: rtl/param_inst_cache_pkg.sv
// rtl/param_inst_cache_pkg.sv - shared state encoding, burst constants and width helper
package param_inst_cache_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    REFILL = 3'd2,
    DRAIN  = 3'd3,
    INV    = 3'd4
  } state_t;

  localparam logic [2:0] ARSIZE       = 3'd2;
  localparam logic [1:0] ARBURST_INCR = 2'b01;

  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/param_inst_cache_if.sv
// rtl/param_inst_cache_if.sv - fetch-side and AXI read-master signals of the instruction cache
interface param_inst_cache_if;

  logic        flush;
  logic        inv_all;
  logic        inv_busy;
  logic [31:0] addr;
  logic        addr_en;
  logic [31:0] inst_o;
  logic        hit;
  logic        miss;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic        axi_rvalid;
  logic        axi_rlast;

  modport slave (
    input  flush, inv_all, addr, addr_en, axi_arready, axi_rdata, axi_rvalid, axi_rlast,
    output inv_busy, inst_o, hit, miss, axi_araddr, axi_arlen, axi_arvalid
  );

  modport master (
    output flush, inv_all, addr, addr_en, axi_arready, axi_rdata, axi_rvalid, axi_rlast,
    input  inv_busy, inst_o, hit, miss, axi_araddr, axi_arlen, axi_arvalid
  );

endinterface

// File: rtl/param_inst_cache_plru_tree.sv
// rtl/param_inst_cache_plru_tree.sv - tree-PLRU victim select and update for one set
module plru_tree
  import param_inst_cache_pkg::*;
#(
  parameter  int WAYS  = 2,
  localparam int WAY_W = (WAYS > 1) ? log2(WAYS) : 1,
  localparam int PB    = (WAYS == 4) ? 3 : 1
) (
  input  logic [PB-1:0]    bits,
  input  logic [WAY_W-1:0] access_way,
  output logic [WAY_W-1:0] victim,
  output logic [PB-1:0]    bits_next
);

  // Every bit points toward the victim half; an access flips the path away from it.
  if (WAYS == 4) begin : g_tree4
    always_comb begin
      victim    = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
      bits_next = bits;
      bits_next[0] = ~access_way[1];
      if (access_way[1]) bits_next[2] = ~access_way[0];
      else               bits_next[1] = ~access_way[0];
    end
  end else if (WAYS == 2) begin : g_tree2
    assign victim    = bits;
    assign bits_next = ~access_way;
  end else begin : g_single
    assign victim    = '0;
    assign bits_next = bits;
  end

endmodule

// File: rtl/param_inst_cache.sv
// rtl/param_inst_cache.sv - N-way set-associative instruction cache with AXI line refill
module param_inst_cache
  import param_inst_cache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8
) (
  input logic               clk,
  input logic               reset,
  param_inst_cache_if.slave bus
);

  localparam int OFF_W = log2(LINE_WORDS);
  localparam int IDX_W = log2(SETS);
  localparam int TAG_W = 32 - OFF_W - IDX_W - 2;
  localparam int WAY_W = (WAYS > 1) ? log2(WAYS) : 1;
  localparam int PB    = (WAYS == 4) ? 3 : 1;
  localparam int CNT_W = OFF_W + 1;

  state_t state, state_next;

  logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
  logic [31:0]      data_mem [WAYS][SETS][LINE_WORDS];
  logic [WAYS-1:0]  valid    [SETS];
  logic [PB-1:0]    plru     [SETS];

  logic [TAG_W-1:0] line_tag;
  logic [IDX_W-1:0] line_idx;
  logic [WAY_W-1:0] victim_q;
  logic [CNT_W-1:0] beat;
  logic [IDX_W-1:0] inv_idx;
  logic             drain_pend, inv_pend, miss_q, arvalid_q, inv_busy_q;

  logic [OFF_W-1:0] f_word;
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             unused_ok;

  assign f_word    = bus.addr[OFF_W+1:2];
  assign f_idx     = bus.addr[OFF_W+IDX_W+1:OFF_W+2];
  assign f_tag     = bus.addr[31:OFF_W+IDX_W+2];
  assign unused_ok = &{1'b0, bus.addr[1:0]};

  logic             hit_any, hit_now, free_found;
  logic [WAY_W-1:0] hit_way, free_way;

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[f_idx][w] && (tag_mem[w][f_idx] == f_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[f_idx][w]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
    end
  end

  assign hit_now    = (state == IDLE) && bus.addr_en && !bus.flush && !reset && hit_any;
  assign bus.hit    = hit_now;
  assign bus.inst_o = hit_now ? data_mem[hit_way][f_idx][f_word] : 32'd0;

  // One PLRU port serves both hit updates (IDLE) and refill completion (REFILL).
  logic [IDX_W-1:0] pl_idx;
  logic [WAY_W-1:0] pl_access, pl_victim;
  logic [PB-1:0]    pl_next;

  assign pl_idx    = (state == IDLE) ? f_idx : line_idx;
  assign pl_access = (state == IDLE) ? hit_way : victim_q;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits       (plru[pl_idx]),
    .access_way (pl_access),
    .victim     (pl_victim),
    .bits_next  (pl_next)
  );

  logic start_fill, start_inv, ar_fire, beat_wr, line_done, drain_done, enter_drain;

  always_comb begin
    state_next  = state;
    start_fill  = 1'b0;
    start_inv   = 1'b0;
    ar_fire     = 1'b0;
    beat_wr     = 1'b0;
    line_done   = 1'b0;
    drain_done  = 1'b0;
    enter_drain = 1'b0;
    case (state)
      IDLE: begin
        if (bus.inv_all || inv_pend) begin
          state_next = INV;
          start_inv  = 1'b1;
        end else if (bus.addr_en && !bus.flush && !hit_any) begin
          state_next = REQ;
          start_fill = 1'b1;
        end
      end
      REQ: begin
        if (bus.axi_arready) begin
          ar_fire = 1'b1;
          if (drain_pend || bus.flush) begin
            state_next  = DRAIN;
            enter_drain = 1'b1;
          end else begin
            state_next = REFILL;
          end
        end
      end
      REFILL: begin
        if (bus.flush) begin
          enter_drain = 1'b1;
          if (bus.axi_rvalid && bus.axi_rlast) begin
            state_next = IDLE;
            drain_done = 1'b1;
          end else begin
            state_next = DRAIN;
          end
        end else if (bus.axi_rvalid) begin
          beat_wr = (beat < CNT_W'(LINE_WORDS));
          if (bus.axi_rlast) begin
            state_next = IDLE;
            line_done  = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (bus.axi_rvalid && bus.axi_rlast) begin
          state_next = IDLE;
          drain_done = 1'b1;
        end
      end
      INV: begin
        if (inv_idx == IDX_W'(SETS - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_q     <= 1'b0;
      arvalid_q  <= 1'b0;
      inv_busy_q <= 1'b0;
      drain_pend <= 1'b0;
      inv_pend   <= 1'b0;
      beat       <= '0;
      inv_idx    <= '0;
      line_tag   <= '0;
      line_idx   <= '0;
      victim_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        plru[s]  <= '0;
      end
    end else begin
      if (hit_now) plru[f_idx] <= pl_next;
      if (start_fill) begin
        line_tag   <= f_tag;
        line_idx   <= f_idx;
        victim_q   <= free_found ? free_way : pl_victim;
        miss_q     <= 1'b1;
        arvalid_q  <= 1'b1;
        drain_pend <= 1'b0;
      end
      if (start_inv) begin
        inv_busy_q <= 1'b1;
        inv_idx    <= '0;
        inv_pend   <= 1'b0;
      end else if (bus.inv_all && (state inside {REQ, REFILL, DRAIN})) begin
        inv_pend <= 1'b1;
      end
      if ((state == REQ) && bus.flush) drain_pend <= 1'b1;
      if (ar_fire) begin
        arvalid_q <= 1'b0;
        beat      <= '0;
      end
      if (beat_wr) beat <= beat + CNT_W'(1);
      // A half-written line must never become visible to a later hit.
      if (enter_drain) valid[line_idx][victim_q] <= 1'b0;
      if (line_done) begin
        valid[line_idx][victim_q] <= 1'b1;
        plru[line_idx]            <= pl_next;
        miss_q                    <= 1'b0;
      end
      if (drain_done) miss_q <= 1'b0;
      if (state == INV) begin
        valid[inv_idx] <= '0;
        plru[inv_idx]  <= '0;
        inv_idx        <= inv_idx + IDX_W'(1);
        if (inv_idx == IDX_W'(SETS - 1)) inv_busy_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_wr) begin
      data_mem[victim_q][line_idx][beat[OFF_W-1:0]] <= bus.axi_rdata;
      if (beat == '0) tag_mem[victim_q][line_idx] <= line_tag;
    end
  end

  assign bus.miss        = miss_q;
  assign bus.axi_arvalid = arvalid_q;
  assign bus.inv_busy    = inv_busy_q;
  assign bus.axi_araddr  = {line_tag, line_idx, {OFF_W{1'b0}}, 2'b00};
  assign bus.axi_arlen   = 8'(LINE_WORDS - 1);

endmodule

// File: tb/tb_param_inst_cache.sv
// tb/tb_param_inst_cache.sv - directed bench for param_inst_cache in two parameter sets
module tb_param_inst_cache;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  param_inst_cache_if ia ();
  param_inst_cache_if ib ();

  param_inst_cache #(.WAYS(2), .SETS(128), .LINE_WORDS(8)) dut_a (
    .clk(clk), .reset(reset), .bus(ia.slave)
  );
  param_inst_cache #(.WAYS(4), .SETS(16), .LINE_WORDS(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ib.slave)
  );

  // sel=0 drives the default-parameter cache, sel=1 the 4-way/16-set/4-word one.
  logic        sel, flush, inv_all, addr_en, arready, rvalid, rlast;
  logic [31:0] addr, rdata;

  assign ia.flush = flush & ~sel;     assign ib.flush = flush & sel;
  assign ia.inv_all = inv_all & ~sel; assign ib.inv_all = inv_all & sel;
  assign ia.addr_en = addr_en & ~sel; assign ib.addr_en = addr_en & sel;
  assign ia.axi_arready = arready & ~sel; assign ib.axi_arready = arready & sel;
  assign ia.axi_rvalid = rvalid & ~sel;   assign ib.axi_rvalid = rvalid & sel;
  assign ia.axi_rlast = rlast;   assign ib.axi_rlast = rlast;
  assign ia.addr = addr;         assign ib.addr = addr;
  assign ia.axi_rdata = rdata;   assign ib.axi_rdata = rdata;

  logic        o_hit, o_miss, o_arvalid, o_busy;
  logic [31:0] o_inst, o_araddr;
  logic [7:0]  o_arlen;
  assign o_hit     = sel ? ib.hit : ia.hit;
  assign o_miss    = sel ? ib.miss : ia.miss;
  assign o_arvalid = sel ? ib.axi_arvalid : ia.axi_arvalid;
  assign o_busy    = sel ? ib.inv_busy : ia.inv_busy;
  assign o_inst    = sel ? ib.inst_o : ia.inst_o;
  assign o_araddr  = sel ? ib.axi_araddr : ia.axi_araddr;
  assign o_arlen   = sel ? ib.axi_arlen : ia.axi_arlen;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic probe(input logic [31:0] a, input logic eh, input logic [31:0] ei, input string tag);
    @(negedge clk);
    addr = a; addr_en = 1'b1;
    #1;
    chk({tag, "_hit"}, 32'(o_hit), 32'(eh));
    chk({tag, "_inst"}, o_inst, ei);
    #1 addr_en = 1'b0;
  endtask

  task automatic touch(input logic [31:0] a);
    @(negedge clk);
    addr = a; addr_en = 1'b1;
    @(negedge clk);
    addr_en = 1'b0;
  endtask

  task automatic request(input logic [31:0] a, input int ar_wait, input string tag);
    logic [31:0] line;
    line = a & (sel ? 32'hFFFF_FFF0 : 32'hFFFF_FFE0);
    @(negedge clk);
    addr = a; addr_en = 1'b1;
    #1 chk({tag, "_cold_hit"}, 32'(o_hit), 0);
    @(negedge clk);
    addr_en = 1'b0; arready = (ar_wait == 0);
    #1;
    chk({tag, "_arvalid"}, 32'(o_arvalid), 1);
    chk({tag, "_araddr"}, o_araddr, line);
    chk({tag, "_miss_set"}, 32'(o_miss), 1);
    chk({tag, "_arlen"}, 32'(o_arlen), sel ? 32'd3 : 32'd7);
    for (int k = 1; k <= ar_wait; k++) begin
      @(negedge clk);
      arready = (k == ar_wait);
      #1;
      chk({tag, "_arvalid_hold"}, 32'(o_arvalid), 1);
      chk({tag, "_araddr_hold"}, o_araddr, line);
    end
    @(negedge clk);
    arready = 1'b0;
    #1 chk({tag, "_arvalid_drop"}, 32'(o_arvalid), 0);
  endtask

  task automatic beats(input logic [31:0] base, input bit gap, input string tag);
    int nw;
    nw = sel ? 4 : 8;
    for (int i = 0; i < nw; i++) begin
      if (gap) begin
        rvalid = 1'b0; rlast = 1'b0;
        @(negedge clk);
      end
      rvalid = 1'b1; rdata = base + 32'(i); rlast = (i == nw - 1);
      #1 chk({tag, "_miss_hold"}, 32'(o_miss), 1);
      @(negedge clk);
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1 chk({tag, "_miss_clear"}, 32'(o_miss), 0);
  endtask

  task automatic refill(input logic [31:0] a, input logic [31:0] base, input int ar_wait,
                        input bit gap, input string tag);
    request(a, ar_wait, tag);
    beats(base, gap, tag);
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (o_busy && n < 400) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk(tag, 32'(n), 32'd128);
  endtask

  initial begin
    sel = 1'b0; flush = 1'b0; inv_all = 1'b0; addr_en = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rlast = 1'b0; addr = '0; rdata = '0; reset = 1'b1;

    // reset state
    @(negedge clk);
    addr = 32'h0000_1000; addr_en = 1'b1;
    #1;
    chk("rst_hit", 32'(o_hit), 0);
    chk("rst_miss", 32'(o_miss), 0);
    chk("rst_arvalid", 32'(o_arvalid), 0);
    chk("rst_inv_busy", 32'(o_busy), 0);
    chk("rst_arlen", 32'(o_arlen), 32'd7);
    addr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // cold miss and same-cycle hit
    refill(32'h0000_1004, 32'hA0, 2, 1'b0, "cold");
    probe(32'h0000_1004, 1'b1, 32'hA1, "cold_w1");
    probe(32'h0000_101C, 1'b1, 32'hA7, "cold_w7");

    // 2-way replacement: the hit on 0x1000 steers eviction to 0x2000
    refill(32'h0000_2000, 32'hB0, 0, 1'b0, "fill2");
    touch(32'h0000_1000);
    refill(32'h0000_3000, 32'hC0, 1, 1'b0, "fill3");
    probe(32'h0000_1000, 1'b1, 32'hA0, "repl_keep");
    probe(32'h0000_2000, 1'b0, 32'h0, "repl_evict");
    probe(32'h0000_3008, 1'b1, 32'hC2, "repl_new");

    // flush on beat 3 of a refill
    request(32'h0000_5040, 0, "fl_ref");
    for (int i = 0; i < 8; i++) begin
      rvalid = 1'b1; rdata = 32'hD0 + 32'(i); rlast = (i == 7); flush = (i == 3);
      if (i == 5) begin
        addr = 32'h0000_1000; addr_en = 1'b1;
        #1 chk("drain_no_hit", 32'(o_hit), 0);
        addr_en = 1'b0;
      end
      #1 chk("fl_ref_miss_hold", 32'(o_miss), 1);
      @(negedge clk);
    end
    rvalid = 1'b0; rlast = 1'b0; flush = 1'b0;
    #1 chk("fl_ref_miss_clear", 32'(o_miss), 0);
    probe(32'h0000_5040, 1'b0, 32'h0, "fl_ref_gone");
    refill(32'h0000_5040, 32'hE0, 0, 1'b0, "fl_ref_again");
    probe(32'h0000_504C, 1'b1, 32'hE3, "fl_ref_new");

    // flush while the AR request waits 5 cycles for arready
    @(negedge clk);
    addr = 32'h0000_6080; addr_en = 1'b1;
    @(negedge clk);
    addr_en = 1'b0; flush = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) flush = 1'b0;
      #1;
      chk("fl_req_arvalid", 32'(o_arvalid), 1);
      chk("fl_req_araddr", o_araddr, 32'h0000_6080);
    end
    @(negedge clk);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    #1 chk("fl_req_arvalid_drop", 32'(o_arvalid), 0);
    beats(32'h60, 1'b0, "fl_req");
    probe(32'h0000_6080, 1'b0, 32'h0, "fl_req_no_line");
    probe(32'h0000_1000, 1'b1, 32'hA0, "fl_req_idle");

    // invalidate-all from IDLE
    @(negedge clk);
    inv_all = 1'b1;
    @(negedge clk);
    inv_all = 1'b0;
    #1 count_busy("inv_len");
    probe(32'h0000_1000, 1'b0, 32'h0, "inv_1000");
    probe(32'h0000_3000, 1'b0, 32'h0, "inv_3000");
    probe(32'h0000_5040, 1'b0, 32'h0, "inv_5040");

    // invalidate-all requested during REQ runs after the refill
    @(negedge clk);
    addr = 32'h0000_7000; addr_en = 1'b1;
    @(negedge clk);
    addr_en = 1'b0; inv_all = 1'b1;
    #1 chk("inv_pend_idle", 32'(o_busy), 0);
    @(negedge clk);
    inv_all = 1'b0; arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    beats(32'hF0, 1'b0, "inv_pend");
    chk("inv_pend_wait", 32'(o_busy), 0);
    @(negedge clk);
    #1 count_busy("inv_pend_len");
    probe(32'h0000_7000, 1'b0, 32'h0, "inv_pend_7000");

    // asynchronous reset while an AR request is outstanding
    @(negedge clk);
    addr = 32'h0000_1000; addr_en = 1'b1;
    @(negedge clk);
    addr_en = 1'b0;
    #1 chk("rst_mid_arvalid_pre", 32'(o_arvalid), 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_arvalid", 32'(o_arvalid), 0);
    chk("rst_mid_miss", 32'(o_miss), 0);
    @(negedge clk);
    reset = 1'b0;
    refill(32'h0000_1000, 32'hA0, 0, 1'b0, "post_rst");
    probe(32'h0000_1010, 1'b1, 32'hA4, "post_rst_w4");

    // 4-way, 16 sets, 4 words: PLRU victim against a hand-walked tree
    sel = 1'b1;
    #1 chk("b_arlen", 32'(o_arlen), 32'd3);
    refill(32'h0000_0104, 32'h10, 1, 1'b1, "b_t1");
    refill(32'h0000_0200, 32'h20, 0, 1'b1, "b_t2");
    refill(32'h0000_0300, 32'h30, 0, 1'b1, "b_t3");
    refill(32'h0000_0400, 32'h40, 0, 1'b1, "b_t4");
    probe(32'h0000_010C, 1'b1, 32'h13, "b_t1_w3");
    touch(32'h0000_0100);
    refill(32'h0000_0500, 32'h50, 2, 1'b1, "b_t5");
    probe(32'h0000_0300, 1'b0, 32'h0, "b_t5_evict3");
    probe(32'h0000_0100, 1'b1, 32'h10, "b_t5_keep1");
    probe(32'h0000_0204, 1'b1, 32'h21, "b_t5_keep2");
    probe(32'h0000_0408, 1'b1, 32'h42, "b_t5_keep4");
    probe(32'h0000_050C, 1'b1, 32'h53, "b_t5_new");
    refill(32'h0000_0600, 32'h60, 0, 1'b1, "b_t6");
    probe(32'h0000_0200, 1'b0, 32'h0, "b_t6_evict2");
    probe(32'h0000_0100, 1'b1, 32'h10, "b_t6_keep1");
    probe(32'h0000_0400, 1'b1, 32'h40, "b_t6_keep4");
    probe(32'h0000_0504, 1'b1, 32'h51, "b_t6_keep5");
    probe(32'h0000_0600, 1'b1, 32'h60, "b_t6_new");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/param_inst_cache.md
Name: param_inst_cache

Overview:
- Parametrised N-way set-associative instruction cache between instruction fetch and the AXI read master. Successor to the fixed 2-way/128-set/8-word fetch cache.
- Adds configurable ways, sets and line size, tree-PLRU replacement, and an owned AR handshake.
- Adds flush-safe refill draining and an invalidate-all sequencer for FENCE.I/cache-op support.
- Tag/data storage is internal register arrays with asynchronous read, so a hit is same-cycle.

Parameters:
- WAYS, 2, associativity; legal values 1, 2, 4.
- SETS, 128, number of sets; power of two, 2..256.
- LINE_WORDS, 8, 32-bit words per line; power of two, 2..16.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- flush  in  1  pipeline flush; abandons the current fetch
- inv_all  in  1  pulse: invalidate every line
- inv_busy  out  1  high while invalidation is in progress
- addr  in  32  fetch address; bits [1:0] ignored
- addr_en  in  1  fetch request valid
- inst_o  out  32  hit instruction; 0 when hit=0
- hit  out  1  combinational hit
- miss  out  1  registered; high from the cycle after a miss until refill completes
- axi_araddr  out  32  line-aligned refill address
- axi_arlen  out  8  constant LINE_WORDS-1
- axi_arvalid  out  1  AR valid
- axi_arready  in  1  AR ready
- axi_rdata  in  32  R data
- axi_rvalid  in  1  R valid
- axi_rlast  in  1  R last beat

Behaviour:
- Address split:
  - OFF_W = log2(LINE_WORDS)
  - IDX_W = log2(SETS)
  - word = addr[OFF_W+1:2]
  - index = addr[OFF_W+IDX_W+1:OFF_W+2]
  - tag = addr[31:OFF_W+IDX_W+2]
- Reset (async): state=IDLE, all valid bits 0, PLRU bits 0, miss=0, axi_arvalid=0, inv_busy=0. Tag/data arrays are not reset.
- hit = 1 when all of the following hold:
  - state==IDLE, addr_en=1, flush=0, reset=0;
  - some way has valid and its tag matches.
  - inst_o then carries that way's word, same cycle.
  - Multiple matching ways cannot occur by construction.
- On a hit, the PLRU for the index is updated to point away from the hit way at the next edge.
- IDLE:
  - addr_en=1 with no hit and flush=0: latch tag/index (the line address) and choose the victim, then go to REQ.
  - Victim rule: the lowest-numbered invalid way; otherwise the PLRU victim.
  - miss is set to 1 and axi_arvalid is set to 1.
  - inv_all=1 takes priority over a fetch: go to INV, set inv_busy=1, clear the set counter.
- REQ:
  - Hold axi_arvalid and axi_araddr stable until axi_arready.
  - Handshake completes: go to REFILL (or DRAIN if flush was seen during REQ), beat counter=0.
  - flush during REQ does not drop arvalid; it only sets a pending-drain flag.
- REFILL:
  - Each axi_rvalid beat writes axi_rdata into data[victim][index][beat] and increments the counter.
  - The tag is written on beat 0.
  - On the beat with axi_rlast=1: set valid[victim][index], update PLRU to protect the victim, clear miss, go to IDLE.
  - rvalid gaps are tolerated; the counter holds.
  - Beats beyond LINE_WORDS without rlast are a protocol error; excess writes are ignored (the counter saturates).
- DRAIN (new):
  - Entered on flush during REFILL, or after REQ with a pending drain.
  - Consume R beats without writing data. valid[victim][index] is cleared on entry so a half-written line can never hit.
  - On rlast: miss=0, go to IDLE.
  - hit is forced 0 until IDLE.
- INV:
  - One set per cycle: clear valid of all ways and PLRU of that set.
  - After set SETS-1 is cleared: inv_busy=0, go to IDLE. Latency is exactly SETS cycles.
  - flush is ignored in INV.
  - An inv_all arriving during REQ/REFILL/DRAIN is latched and serviced on return to IDLE.
- flush in IDLE: no effect on state; it only suppresses hit and miss initiation that cycle.
- A reset asserted mid-refill returns to IDLE immediately. The interconnect is reset with the same signal, so no drain is required.
- PLRU:
  - WAYS=1: no bits, victim 0.
  - WAYS=2: 1 bit per set.
  - WAYS=4: 3-bit tree per set, with bit0 = root.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/REQ/REFILL/DRAIN/INV;
  - burst constants: ARSIZE=2, ARBURST=INCR;
  - a log2 function for width derivation.
- Sub-module plru_tree(WAYS): combinational victim-select from the set's bits, plus next-state bits given the accessed way. Used for both the hit update and the refill update.

Test Plan:
- Cold miss, defaults, addr=0x0000_1004, arready after 2 cycles, 8 beats 0xA0..0xA7 with rlast on the 8th:
  - araddr=0x0000_1000, arlen=7;
  - miss=1 until the rlast cycle;
  - re-fetch 0x0000_1004 gives hit=1, inst_o=0xA1 in the same cycle.
- Replacement, WAYS=2:
  - fill tags for 0x1000 and 0x2000 (same index);
  - hit 0x1000;
  - fetch 0x3000, which misses and evicts the 0x2000 way;
  - 0x1000 still hits, 0x2000 misses.
- Flush mid-refill: flush on beat 3 of 8:
  - no further data writes; miss drops on rlast;
  - the same addr then misses again and issues a new AR.
- Flush during REQ with arready held low 5 cycles:
  - arvalid stays high and araddr stable until the handshake;
  - all 8 beats drained, no valid line created.
- Invalidate-all, SETS=128, lines resident:
  - inv_busy high exactly 128 cycles;
  - afterwards every previously resident address misses.
- Parameter sweep WAYS=4, SETS=16, LINE_WORDS=4:
  - arlen=3; five distinct tags to one set;
  - the PLRU victim matches the reference model, and rvalid gaps are absorbed.
